// File: rtl/hazard_pkg.sv
// Types and helpers shared by the hazard/control unit and its RAW comparator.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        INSERT
    } trap_state_t;

    // One pipeline register separates each pair of adjacent stages.
    function automatic int NUM_BOUNDARIES(input int num_stages);
        return num_stages - 1;
    endfunction

endpackage

// File: rtl/rv32i_types_pkg.sv
// Basic RV32I data types that are shared across the core.
package rv32i_types_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/hazard_raw_detect.sv
// Compares the execute-stage sources against every younger-than-commit writer
// and flags a read-after-write hazard that forwarding cannot cover.
module hazard_raw_detect #(
    parameter int NUM_STAGES = 3,
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic [4:0]                  rs1_e,
    input  logic [4:0]                  rs2_e,
    input  logic [5*(NUM_STAGES-2)-1:0] rd_vec,
    input  logic [NUM_STAGES-3:0]       wen_vec,
    input  logic [NUM_STAGES-3:0]       load_vec,
    input  logic [NUM_STAGES-1:1]       valid_vec,
    output logic                        raw_hazard
);

    logic any_match;

    // Slot j describes stage j+2; x0 is never a real dependency.
    always_comb begin
        any_match = 1'b0;
        for (int j = 0; j < NUM_STAGES - 2; j++) begin
            if (wen_vec[j] && valid_vec[j+2] &&
                (rd_vec[5*j +: 5] != 5'd0) &&
                ((rd_vec[5*j +: 5] == rs1_e) || (rd_vec[5*j +: 5] == rs2_e)) &&
                (FORWARD_EN ? load_vec[j] : 1'b1)) begin
                any_match = 1'b1;
            end
        end
    end

    assign raw_hazard = any_match & valid_vec[1];

endmodule

// File: rtl/stagen_hazard_unit.sv
// Hazard/control unit for an N-stage in-order RV32 pipeline: stall/flush
// generation, a drain-then-redirect trap sequencer and a stall-cycle counter.
module stagen_hazard_unit
    import hazard_pkg::*;
    import rv32i_types_pkg::*;
#(
    parameter int NUM_STAGES     = 3,
    parameter bit FORWARD_EN     = 1'b1,
    parameter int REDIRECT_STAGE = NUM_STAGES - 1,
    parameter int CNT_W          = 32
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic [4:0]                               rs1_e,
    input  logic [4:0]                               rs2_e,
    input  logic [5*(NUM_STAGES-2)-1:0]              rd_vec,
    input  logic [NUM_STAGES-3:0]                    wen_vec,
    input  logic [NUM_STAGES-3:0]                    load_vec,
    input  logic [NUM_STAGES-1:0]                    valid_vec,
    input  logic                                     i_mem_busy,
    input  logic                                     d_mem_busy,
    input  logic                                     fence_stall,
    input  logic                                     redirect,
    input  logic                                     trap_req,
    input  word_t                                    trap_pc,
    output logic                                     pc_en,
    output logic                                     npc_sel,
    output logic [NUM_BOUNDARIES(NUM_STAGES)-1:0]    stall_vec,
    output logic [NUM_BOUNDARIES(NUM_STAGES)-1:0]    flush_vec,
    output logic                                     insert_priv_pc,
    output word_t                                    priv_pc,
    output logic                                     iren,
    output logic                                     suppress_data,
    output logic [CNT_W-1:0]                         stall_cnt,
    input  logic                                     cnt_clr
);

    localparam int NB = NUM_BOUNDARIES(NUM_STAGES);

    // A resolved redirect squashes everything younger than the resolving stage.
    function automatic logic [NB-1:0] redirect_mask();
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) begin
            m[i] = (i < REDIRECT_STAGE);
        end
        return m;
    endfunction

    localparam logic [NB-1:0] REDIR_MASK = redirect_mask();

    trap_state_t   state;
    logic          raw_hazard;
    logic [NB-1:0] stall_req;
    logic [NB-1:0] flush_req;
    logic          unused_valid0;

    assign unused_valid0 = valid_vec[0];

    hazard_raw_detect #(
        .NUM_STAGES (NUM_STAGES),
        .FORWARD_EN (FORWARD_EN)
    ) u_raw_detect (
        .rs1_e      (rs1_e),
        .rs2_e      (rs2_e),
        .rd_vec     (rd_vec),
        .wen_vec    (wen_vec),
        .load_vec   (load_vec),
        .valid_vec  (valid_vec[NUM_STAGES-1:1]),
        .raw_hazard (raw_hazard)
    );

    always_comb begin
        pc_en     = 1'b1;
        npc_sel   = 1'b0;
        iren      = 1'b1;
        stall_req = '0;
        flush_req = '0;
        unique case (state)
            IDLE: begin
                if (trap_req) begin
                    pc_en     = 1'b0;
                    flush_req = '1;
                end else if (d_mem_busy || fence_stall) begin
                    pc_en     = 1'b0;
                    stall_req = '1;
                end else if (redirect) begin
                    npc_sel   = 1'b1;
                    flush_req = REDIR_MASK;
                end else if (raw_hazard) begin
                    pc_en        = 1'b0;
                    stall_req[0] = 1'b1;
                    flush_req[1] = 1'b1;
                end else if (i_mem_busy) begin
                    pc_en        = 1'b0;
                    flush_req[0] = 1'b1;
                end
            end
            DRAIN: begin
                pc_en     = 1'b0;
                iren      = 1'b0;
                flush_req = '1;
            end
            INSERT: begin
                flush_req = '1;
            end
            default: begin
                pc_en = 1'b0;
            end
        endcase
    end

    assign stall_vec = stall_req & ~flush_req;
    assign flush_vec = flush_req;

    // Trap sequencer: hold the pipe empty until both memory ports go quiet,
    // then spend one cycle loading the latched vector into the PC.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= IDLE;
            priv_pc        <= '0;
            insert_priv_pc <= 1'b0;
            suppress_data  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trap_req) begin
                        state         <= DRAIN;
                        priv_pc       <= trap_pc;
                        suppress_data <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!i_mem_busy && !d_mem_busy) begin
                        state          <= INSERT;
                        insert_priv_pc <= 1'b1;
                    end
                end
                INSERT: begin
                    state          <= IDLE;
                    insert_priv_pc <= 1'b0;
                    suppress_data  <= 1'b0;
                end
                default: begin
                    state          <= IDLE;
                    insert_priv_pc <= 1'b0;
                    suppress_data  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && !pc_en && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/stagen_hazard_unit.md
Name: stagen_hazard_unit

Overview:
- Parametrised hazard/control unit for an N-stage in-order RV32 pipeline. Stage 0 is fetch, stage 1 is execute, stage N-1 is mem/commit.
- Generates the PC enable, per-boundary stall and flush vectors, and instruction/data request suppression.
- Contains a trap-insertion FSM that drains outstanding memory traffic before redirecting to the privileged vector.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
NUM_STAGES, 3, pipeline depth (>=3); boundary k sits between stage k and stage k+1
FORWARD_EN, 1, 1 = full forwarding, so only loads cause RAW stalls; 0 = any pending write stalls
REDIRECT_STAGE, NUM_STAGES-1, stage that resolves jumps/mispredicts (1..NUM_STAGES-1)
CNT_W, 32, stall counter width

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
rs1_e, rs2_e  in  5 each  execute-stage source registers
rd_vec  in  5*(NUM_STAGES-2)  dest reg of stages 2..N-1; slot j = stage j+2
wen_vec  in  NUM_STAGES-2  stage writes a register
load_vec  in  NUM_STAGES-2  stage holds a load whose data is not yet available
valid_vec  in  NUM_STAGES  stage holds a valid instruction
i_mem_busy, d_mem_busy, fence_stall  in  1 each  memory-side stall sources
redirect  in  1  jump/mispredict resolved in REDIRECT_STAGE
trap_req  in  1  exception, interrupt or ret committed in stage N-1
trap_pc  in  32  target vector / return PC for trap_req
pc_en  out  1  advance PC
npc_sel  out  1  select redirect target
stall_vec  out  NUM_STAGES-1  hold boundary k
flush_vec  out  NUM_STAGES-1  bubble boundary k
insert_priv_pc  out  1  load priv_pc into PC
priv_pc  out  32  latched trap target
iren  out  1  instruction fetch request enable
suppress_data  out  1  block dren/dwen of stage N-1
stall_cnt  out  CNT_W  cycles with pc_en=0 in state IDLE
cnt_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Reset values:
  - FSM returns to IDLE.
  - priv_pc=0, stall_cnt=0, insert_priv_pc=0, suppress_data=0.
  - Combinational outputs take their IDLE, no-hazard values: pc_en=1, iren=1, npc_sel=0, stall_vec=0, flush_vec=0.
- RAW hazard: true when any slot j has wen_vec[j] & valid_vec[j+2] & rd!=0 & rd matches rs1_e or rs2_e & (FORWARD_EN ? load_vec[j] : 1) & valid_vec[1].
- IDLE priority (highest first):
  1. trap_req: latch trap_pc into priv_pc, go to DRAIN, flush all boundaries, pc_en=0.
  2. d_mem_busy or fence_stall: stall all boundaries, pc_en=0. A concurrent redirect is held and not taken.
  3. redirect: pc_en=1, npc_sel=1, flush boundaries 0..REDIRECT_STAGE-1.
  4. RAW: pc_en=0, stall boundary 0, flush boundary 1 (bubble).
  5. i_mem_busy: pc_en=0, flush boundary 0.
- A boundary is never both stalled and flushed; flush wins.
- DRAIN state:
  - pc_en=0, iren=0, suppress_data=1, all flush_vec=1.
  - Further trap_req and redirect inputs are ignored.
  - Stay until i_mem_busy=0 and d_mem_busy=0 in the same cycle, then go to INSERT next cycle. If both are already 0, DRAIN still lasts exactly 1 cycle.
- INSERT state: one cycle. insert_priv_pc=1, pc_en=1, all flush_vec=1, suppress_data=1. Then go to IDLE.
- Trap latency: trap_req at cycle t gives insert_priv_pc at t+2 minimum.
- stall_cnt:
  - Increments each IDLE cycle with pc_en=0.
  - Saturates at all-ones, no wrap-around.
  - cnt_clr has priority over increment.
- Asserting RST mid-DRAIN or mid-INSERT aborts the trap with no insert_priv_pc pulse.

Decomposition:
- Shared package `hazard_pkg`: FSM enum `trap_state_t` {IDLE, DRAIN, INSERT} and a `NUM_BOUNDARIES` function. `word_t` comes from `rv32i_types_pkg`.
- One sub-module, `hazard_raw_detect`: purely combinational N-slot comparator producing the RAW flag.

Test Plan:
- RAW stall: NUM_STAGES=3, FORWARD_EN=1, load in stage 2 with rd=5, rs1_e=5 -> pc_en=0, stall_vec=2'b01, flush_vec=2'b10. With rd=0 instead -> no stall.
- Redirect blocked by memory: redirect together with d_mem_busy=1 for 3 cycles -> stall_vec=2'b11 and npc_sel=0 for those cycles; the cycle after busy drops -> npc_sel=1, flush_vec=2'b11.
- Trap drain: trap_req with trap_pc=0x8000_0100 while d_mem_busy=1 for 4 cycles -> DRAIN lasts 4 cycles with suppress_data=1; INSERT follows with insert_priv_pc=1 and priv_pc=0x8000_0100.
- Trap priority: trap_req and redirect in the same cycle -> npc_sel=0 and FSM enters DRAIN. A second trap_req during DRAIN leaves priv_pc unchanged.
- Counter: CNT_W=4 with 20 stall cycles -> stall_cnt=4'hF. cnt_clr together with a stall -> stall_cnt=0.
- Reset mid-trap: assert RST during DRAIN -> immediate return to IDLE, no insert_priv_pc pulse, priv_pc=0.
